// File: rtl/coherence_bus_ctrl_pkg.sv
// coherence_pkg: shared types and helpers for the snooping coherence bus controller
// Contents:
//   bus_state_t  controller FSM states
//   req_class_t  decoded core request class (read miss, read-exclusive/upgrade, write-back)
//   WORD_BYTES   bytes per data word
//   blk_align    aligns a byte address down to the start of its block
package coherence_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_SUPPLY,
        ST_MEMRD,
        ST_INV,
        ST_WB
    } bus_state_t;

    typedef enum logic [1:0] {
        RD,
        RDX,
        WB
    } req_class_t;

    localparam int WORD_BYTES = 4;

    // Works on a 64-bit container so one helper serves any AW up to 64.
    function automatic logic [63:0] blk_align(input logic [63:0] addr, input int words);
        return addr & ~(64'(words * WORD_BYTES) - 64'd1);
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if: per-core dcache request/snoop signals plus the shared memory data port
// Signals:
//   dREN, dWEN, cctrans, ccwrite  per-core request flags (core -> ctrl)
//   daddr, dstore                 per-core block address and write/supply data (core -> ctrl)
//   dwait, dload                  per-core stall and read data (ctrl -> core)
//   ccwait, ccinv, ccsnoopaddr    per-core snoop, invalidate and snoop address (ctrl -> core)
//   ram_ren, ram_wen, ram_addr, ram_store  memory strobes, address and write data (ctrl -> mem)
//   ram_load, ram_wait            memory read data and stall (mem -> ctrl)
// Modports: master is the controller view, slave is the caches-plus-memory view.
interface coherence_bus_ctrl_if #(
    parameter int NCORES = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
);

    logic [NCORES-1:0]         dREN, dWEN, cctrans, ccwrite;
    logic [NCORES-1:0][AW-1:0] daddr;
    logic [NCORES-1:0][DW-1:0] dstore;
    logic [NCORES-1:0]         dwait;
    logic [NCORES-1:0][DW-1:0] dload;
    logic [NCORES-1:0]         ccwait, ccinv;
    logic [NCORES-1:0][AW-1:0] ccsnoopaddr;
    logic                      ram_ren, ram_wen, ram_wait;
    logic [AW-1:0]             ram_addr;
    logic [DW-1:0]             ram_store, ram_load;

    modport master (
        input  dREN, dWEN, cctrans, ccwrite, daddr, dstore, ram_load, ram_wait,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr, ram_ren, ram_wen, ram_addr, ram_store
    );

    modport slave (
        output dREN, dWEN, cctrans, ccwrite, daddr, dstore, ram_load, ram_wait,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ram_ren, ram_wen, ram_addr, ram_store
    );

endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts one past the last granted requester
// Ports:
//   CLK, nRST  clock and asynchronous active-low reset
//   req        request vector
//   advance    commit the current grant as the new last grant
//   grant      one-hot grant (zero when nothing requests)
//   grant_idx  index of the granted requester
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last;

    // Scanning from the farthest candidate back to the nearest leaves the
    // nearest requester after "last" as the final winner.
    always_comb begin
        grant_idx = '0;
        for (int i = N; i >= 1; i--)
            if (req[IW'((int'(last) + i) % N)]) grant_idx = IW'((int'(last) + i) % N);
        grant = |req ? N'(1) << grant_idx : '0;
    end

    // Reset to N-1 so core 0 is the first winner.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) last <= IW'(N - 1);
        else if (advance && |req) last <= grant_idx;
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: snooping-bus coherence controller for NCORES L1 dcaches sharing one memory port
// Ports:
//   CLK   clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   coherence_bus_ctrl_if.master: per-core request/snoop signals and memory data port
// Transactions: RD (snoop, then cache-to-cache supply with memory write-back or memory read),
// RDX/upgrade (one-cycle broadcast invalidate) and WB (block write to memory).
module coherence_bus_ctrl
    import coherence_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int WORDS  = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input logic CLK,
    input logic nRST,
    coherence_bus_ctrl_if.master bus
);

    localparam int IW = $clog2(NCORES);
    localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;

    bus_state_t        state;
    req_class_t        win_cls;
    logic [IW-1:0]     req_idx, sup_idx, grant_idx, dirty_idx;
    logic [AW-1:0]     base, word_addr;
    logic [CW-1:0]     cnt;
    logic              last_word;
    logic [NCORES-1:0] rd, rdx, wb, req, grant, others, dirty;

    assign rd        = bus.cctrans & bus.dREN;
    assign rdx       = bus.cctrans & bus.ccwrite & ~bus.dREN;
    assign wb        = bus.dWEN & ~bus.cctrans;
    assign req       = rd | rdx | wb;
    assign win_cls   = |(rd & grant) ? RD : |(rdx & grant) ? RDX : WB;
    assign others    = ~(NCORES'(1) << req_idx);
    // A non-requester raising ccwrite during the snoop holds the block Modified.
    assign dirty     = bus.ccwrite & others;
    assign word_addr = base + AW'(cnt) * AW'(WORD_BYTES);
    assign last_word = cnt == CW'(WORDS - 1);

    always_comb begin
        dirty_idx = '0;
        for (int i = NCORES - 1; i >= 0; i--)
            if (dirty[i]) dirty_idx = IW'(i);
    end

    rr_arbiter #(.N(NCORES)) u_arb (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (req),
        .advance   (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            req_idx <= '0;
            sup_idx <= '0;
            base    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|req) begin
                    req_idx <= grant_idx;
                    base    <= AW'(blk_align(64'(bus.daddr[grant_idx]), WORDS));
                    state   <= win_cls == RD ? ST_SNOOP : win_cls == RDX ? ST_INV : ST_WB;
                end
                ST_SNOOP: begin
                    sup_idx <= dirty_idx;
                    state   <= |dirty ? ST_SUPPLY : ST_MEMRD;
                end
                ST_INV: state <= ST_IDLE;
                // SUPPLY, MEMRD and WB share the word loop paced by ram_wait.
                default: if (!bus.ram_wait) begin
                    cnt <= last_word ? '0 : cnt + 1'b1;
                    if (last_word) state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state; word data and stalls pass straight
    // through from memory or the supplier so each word completes in one cycle.
    always_comb begin
        bus.dwait       = '1;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ram_ren     = 1'b0;
        bus.ram_wen     = 1'b0;
        bus.ram_addr    = '0;
        bus.ram_store   = '0;
        case (state)
            ST_SNOOP, ST_INV: begin
                bus.ccwait = others;
                bus.ccinv  = state == ST_INV ? others : '0;
                for (int i = 0; i < NCORES; i++)
                    bus.ccsnoopaddr[i] = others[i] ? base : '0;
                if (state == ST_INV) bus.dwait[req_idx] = 1'b0;
            end
            ST_SUPPLY: begin
                bus.ram_wen         = 1'b1;
                bus.ram_addr        = word_addr;
                bus.ram_store       = bus.dstore[sup_idx];
                bus.dload[req_idx]  = bus.dstore[sup_idx];
                bus.dwait[req_idx]  = bus.ram_wait;
                bus.dwait[sup_idx]  = bus.ram_wait;
                bus.ccwait[sup_idx] = 1'b1;
            end
            ST_MEMRD: begin
                bus.ram_ren        = 1'b1;
                bus.ram_addr       = word_addr;
                bus.dload[req_idx] = bus.ram_load;
                bus.dwait[req_idx] = bus.ram_wait;
            end
            ST_WB: begin
                bus.ram_wen        = 1'b1;
                bus.ram_addr       = word_addr;
                bus.ram_store      = bus.dstore[req_idx];
                bus.dwait[req_idx] = bus.ram_wait;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed self-checking bench for coherence_bus_ctrl (NCORES=4, WORDS=2)
module tb_coherence_bus_ctrl;

    logic CLK = 1'b0;
    logic nRST;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] rom [0:255];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    coherence_bus_ctrl_if #(.NCORES(4), .AW(32), .DW(32)) bus ();

    coherence_bus_ctrl #(.NCORES(4), .WORDS(2), .AW(32), .DW(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.ram_load = rom[bus.ram_addr[9:2]];

    always @(posedge CLK)
        if (bus.ram_wen === 1'b1 && bus.ram_wait === 1'b0) begin
            wa.push_back(bus.ram_addr);
            wd.push_back(bus.ram_store);
        end

    task automatic idle_inputs();
        bus.dREN    = '0;
        bus.dWEN    = '0;
        bus.cctrans = '0;
        bus.ccwrite = '0;
        bus.daddr   = '0;
        bus.dstore  = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.ram_wait = 1'b0;
        idle_inputs();
        bus.cctrans[0] = 1'b1;
        bus.dREN[0] = 1'b1;
        @(negedge CLK); #1;
        n_cmp++; if (bus.dwait !== 4'hF) begin n_bad++; $display("FAIL reset_dwait: got %h want %h", bus.dwait, 4'hF); end
        n_cmp++; if (bus.ram_ren !== 1'b0 || bus.ram_wen !== 1'b0) begin n_bad++; $display("FAIL reset_ram: got ren=%b wen=%b want 0 0", bus.ram_ren, bus.ram_wen); end
        n_cmp++; if (bus.ccwait !== 4'h0 || bus.ccinv !== 4'h0) begin n_bad++; $display("FAIL reset_cc: got ccwait=%h ccinv=%h want 0 0", bus.ccwait, bus.ccinv); end
        idle_inputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_rd_mem();
        rom[8'h40] = 32'hAA;
        rom[8'h41] = 32'hBB;
        @(negedge CLK);
        bus.cctrans[0] = 1'b1;
        bus.dREN[0] = 1'b1;
        bus.daddr[0] = 32'h100;
        #1;
        n_cmp++; if (bus.dwait !== 4'hF) begin n_bad++; $display("FAIL rd_idle_dwait: got %h want %h", bus.dwait, 4'hF); end
        @(negedge CLK); #1;
        n_cmp++; if (bus.ccwait !== 4'b1110) begin n_bad++; $display("FAIL rd_snoop_ccwait: got %b want 1110", bus.ccwait); end
        n_cmp++; if (bus.ccsnoopaddr[1] !== 32'h100) begin n_bad++; $display("FAIL rd_snoop_addr: got %h want 100", bus.ccsnoopaddr[1]); end
        n_cmp++; if (bus.dwait !== 4'hF) begin n_bad++; $display("FAIL rd_snoop_dwait: got %h want f", bus.dwait); end
        @(negedge CLK); #1;
        n_cmp++; if (bus.ram_ren !== 1'b1 || bus.ram_addr !== 32'h100) begin n_bad++; $display("FAIL rd_w0_ram: got ren=%b addr=%h want 1 100", bus.ram_ren, bus.ram_addr); end
        n_cmp++; if (bus.dload[0] !== 32'hAA || bus.dwait !== 4'b1110) begin n_bad++; $display("FAIL rd_w0_data: got dload=%h dwait=%b want aa 1110", bus.dload[0], bus.dwait); end
        n_cmp++; if (bus.ccinv !== 4'h0) begin n_bad++; $display("FAIL rd_w0_ccinv: got %b want 0000", bus.ccinv); end
        @(negedge CLK); #1;
        n_cmp++; if (bus.ram_addr !== 32'h104) begin n_bad++; $display("FAIL rd_w1_addr: got %h want 104", bus.ram_addr); end
        n_cmp++; if (bus.dload[0] !== 32'hBB || bus.dwait !== 4'b1110) begin n_bad++; $display("FAIL rd_w1_data: got dload=%h dwait=%b want bb 1110", bus.dload[0], bus.dwait); end
        n_cmp++; if (bus.ccinv !== 4'h0) begin n_bad++; $display("FAIL rd_w1_ccinv: got %b want 0000", bus.ccinv); end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_cmp++; if (bus.dwait !== 4'hF || bus.ram_ren !== 1'b0) begin n_bad++; $display("FAIL rd_done: got dwait=%h ren=%b want f 0", bus.dwait, bus.ram_ren); end
    endtask

    task automatic test_supply();
        int n0;
        @(negedge CLK);
        n0 = wa.size();
        bus.cctrans[1] = 1'b1;
        bus.dREN[1] = 1'b1;
        bus.daddr[1] = 32'h200;
        bus.ccwrite[0] = 1'b1;
        bus.dstore[0] = 32'hCC;
        @(negedge CLK); #1;
        n_cmp++; if (bus.ccwait !== 4'b1101) begin n_bad++; $display("FAIL sup_snoop_ccwait: got %b want 1101", bus.ccwait); end
        n_cmp++; if (bus.ccsnoopaddr[0] !== 32'h200) begin n_bad++; $display("FAIL sup_snoop_addr: got %h want 200", bus.ccsnoopaddr[0]); end
        @(negedge CLK); #1;
        n_cmp++; if (bus.ram_wen !== 1'b1 || bus.ram_addr !== 32'h200 || bus.ram_store !== 32'hCC) begin n_bad++; $display("FAIL sup_w0_ram: got wen=%b addr=%h store=%h want 1 200 cc", bus.ram_wen, bus.ram_addr, bus.ram_store); end
        n_cmp++; if (bus.dload[1] !== 32'hCC || bus.dwait !== 4'b1100) begin n_bad++; $display("FAIL sup_w0_data: got dload=%h dwait=%b want cc 1100", bus.dload[1], bus.dwait); end
        n_cmp++; if (bus.ccwait !== 4'b0001) begin n_bad++; $display("FAIL sup_w0_ccwait: got %b want 0001", bus.ccwait); end
        @(negedge CLK);
        bus.dstore[0] = 32'hDD;
        #1;
        n_cmp++; if (bus.ram_addr !== 32'h204 || bus.ram_store !== 32'hDD) begin n_bad++; $display("FAIL sup_w1_ram: got addr=%h store=%h want 204 dd", bus.ram_addr, bus.ram_store); end
        n_cmp++; if (bus.dload[1] !== 32'hDD || bus.ccwait !== 4'b0001) begin n_bad++; $display("FAIL sup_w1_data: got dload=%h ccwait=%b want dd 0001", bus.dload[1], bus.ccwait); end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_cmp++; if (wa.size() !== n0 + 2) begin n_bad++; $display("FAIL sup_wr_count: got %0d want %0d", wa.size(), n0 + 2); end
        else begin
            n_cmp++; if (wa[n0] !== 32'h200 || wd[n0] !== 32'hCC) begin n_bad++; $display("FAIL sup_wr0: got %h=%h want 200=cc", wa[n0], wd[n0]); end
            n_cmp++; if (wa[n0+1] !== 32'h204 || wd[n0+1] !== 32'hDD) begin n_bad++; $display("FAIL sup_wr1: got %h=%h want 204=dd", wa[n0+1], wd[n0+1]); end
        end
    endtask

    task automatic test_rdx();
        @(negedge CLK);
        bus.cctrans[0] = 1'b1;
        bus.ccwrite[0] = 1'b1;
        bus.daddr[0] = 32'h304;
        @(negedge CLK); #1;
        n_cmp++; if (bus.ccinv !== 4'b1110 || bus.ccwait !== 4'b1110) begin n_bad++; $display("FAIL rdx_inv: got ccinv=%b ccwait=%b want 1110 1110", bus.ccinv, bus.ccwait); end
        n_cmp++; if (bus.ccsnoopaddr[3] !== 32'h300 || bus.ccsnoopaddr[0] !== 32'h0) begin n_bad++; $display("FAIL rdx_addr: got [3]=%h [0]=%h want 300 0", bus.ccsnoopaddr[3], bus.ccsnoopaddr[0]); end
        n_cmp++; if (bus.dwait !== 4'b1110) begin n_bad++; $display("FAIL rdx_dwait: got %b want 1110", bus.dwait); end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_cmp++; if (bus.ccinv !== 4'h0 || bus.dwait !== 4'hF) begin n_bad++; $display("FAIL rdx_done: got ccinv=%b dwait=%h want 0000 f", bus.ccinv, bus.dwait); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int c;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        n0 = wa.size();
        for (int i = 0; i < 4; i++) begin
            bus.daddr[i]  = 32'h400 + 32'(16 * i);
            bus.dstore[i] = 32'hD0 + 32'(i);
        end
        bus.dWEN = 4'hF;
        repeat (15) @(negedge CLK);
        idle_inputs();
        #1;
        n_cmp++; if (wa.size() !== n0 + 10) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", wa.size() - n0, 10); end
        else for (int j = 0; j < 10; j++) begin
            c = (j / 2) % 4;
            n_cmp++; if (wa[n0+j] !== 32'h400 + 32'(16 * c + 4 * (j % 2)) || wd[n0+j] !== 32'hD0 + 32'(c)) begin
                n_bad++;
                $display("FAIL b2b_wr%0d: got %h=%h want %h=%h", j, wa[n0+j], wd[n0+j], 32'h400 + 32'(16 * c + 4 * (j % 2)), 32'hD0 + 32'(c));
            end
        end
    endtask

    task automatic test_mem_stall();
        rom[8'h60] = 32'h11;
        rom[8'h61] = 32'h22;
        @(negedge CLK);
        bus.cctrans[2] = 1'b1;
        bus.dREN[2] = 1'b1;
        bus.daddr[2] = 32'h180;
        @(negedge CLK);
        @(negedge CLK); #1;
        n_cmp++; if (bus.dload[2] !== 32'h11 || bus.dwait !== 4'b1011) begin n_bad++; $display("FAIL stall_w0: got dload=%h dwait=%b want 11 1011", bus.dload[2], bus.dwait); end
        @(negedge CLK);
        bus.ram_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (bus.dwait !== 4'hF || bus.ram_addr !== 32'h184 || bus.ram_ren !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d: got dwait=%h addr=%h ren=%b want f 184 1", i, bus.dwait, bus.ram_addr, bus.ram_ren); end
            @(negedge CLK);
        end
        bus.ram_wait = 1'b0;
        #1;
        n_cmp++; if (bus.dwait !== 4'b1011 || bus.dload[2] !== 32'h22 || bus.ram_addr !== 32'h184) begin n_bad++; $display("FAIL stall_release: got dwait=%b dload=%h addr=%h want 1011 22 184", bus.dwait, bus.dload[2], bus.ram_addr); end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_cmp++; if (bus.ram_ren !== 1'b0 || bus.dwait !== 4'hF) begin n_bad++; $display("FAIL stall_done: got ren=%b dwait=%h want 0 f", bus.ram_ren, bus.dwait); end
    endtask

    task automatic test_reset_mid_supply();
        int n0;
        @(negedge CLK);
        bus.cctrans[1] = 1'b1;
        bus.dREN[1] = 1'b1;
        bus.daddr[1] = 32'h200;
        bus.ccwrite[0] = 1'b1;
        bus.dstore[0] = 32'hEE;
        @(negedge CLK);
        @(negedge CLK); #1;
        n_cmp++; if (bus.ram_wen !== 1'b1 || bus.dload[1] !== 32'hEE) begin n_bad++; $display("FAIL rst_pre: got wen=%b dload=%h want 1 ee", bus.ram_wen, bus.dload[1]); end
        n0 = wa.size();
        nRST = 1'b0;
        #1;
        n_cmp++; if (bus.ram_wen !== 1'b0 || bus.ram_addr !== 32'h0) begin n_bad++; $display("FAIL rst_ram: got wen=%b addr=%h want 0 0", bus.ram_wen, bus.ram_addr); end
        n_cmp++; if (bus.dwait !== 4'hF || bus.ccwait !== 4'h0 || bus.dload[1] !== 32'h0) begin n_bad++; $display("FAIL rst_out: got dwait=%h ccwait=%b dload=%h want f 0000 0", bus.dwait, bus.ccwait, bus.dload[1]); end
        @(negedge CLK);
        n_cmp++; if (wa.size() !== n0) begin n_bad++; $display("FAIL rst_no_write: got %0d writes want 0", wa.size() - n0); end
        bus.ccwrite[0] = 1'b0;
        bus.cctrans[0] = 1'b1;
        bus.dREN[0] = 1'b1;
        bus.daddr[0] = 32'h100;
        nRST = 1'b1;
        @(negedge CLK); #1;
        n_cmp++; if (bus.ccwait !== 4'b1110 || bus.ccsnoopaddr[1] !== 32'h100) begin n_bad++; $display("FAIL rst_regrant: got ccwait=%b addr=%h want 1110 100", bus.ccwait, bus.ccsnoopaddr[1]); end
        idle_inputs();
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_rd_mem();
        test_supply();
        test_rdx();
        test_back_to_back();
        test_mem_stall();
        test_reset_mid_supply();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
